mod_shift_mult: RTL and testbench

//  Sequential modular power-of-two multiplier: oData = (iData * 2^iShift) mod iMod.

---
 rtl/mod_shift_pkg.sv | 17 +
 rtl/mod_doubler.sv | 28 ++
 rtl/mod_shift_mult.sv | 151 +++++++++++++++
 tb/tb_mod_shift_mult.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_shift_pkg.sv
// Shared types and constants for the modular shift-multiplier datapath.
package mod_shift_pkg;

  localparam int DEF_BITWIDTH = 32;
  localparam int DEF_SHIFTW   = 5;

  // Operand error code carried on oErr
  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_OPERAND = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_doubler.sv
// Combinational modular doubling: r = (2*a) mod m, valid for a < m.
// Because a < m, 2a < 2m, so one conditional subtract is enough.
module mod_doubler #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] m,
  output logic [BITWIDTH-1:0] r
);

  logic [BITWIDTH-1:0] dblLowS;
  logic                dblCarryS;
  logic                geS;

  // The carry out of the shift is the top bit of 2a; the low-word subtract
  // wraps correctly because the true difference always fits in BITWIDTH bits.
  always_comb begin
    dblLowS   = {a[BITWIDTH-2:0], 1'b0};
    dblCarryS = a[BITWIDTH-1];
    geS       = dblCarryS | (dblLowS >= m);
    if (geS) begin
      r = dblLowS - m;
    end else begin
      r = dblLowS;
    end
  end

endmodule

// File: rtl/mod_shift_mult.sv
// Sequential modular power-of-two multiplier: oData = (iData * 2^iShift) mod iMod.
// One modular doubling per enabled cycle, valid/ready handshake on both sides.
module mod_shift_mult
  import mod_shift_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int SHIFTW   = DEF_SHIFTW
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  input  logic [SHIFTW-1:0]   iShift,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oErr
);

  localparam logic [BITWIDTH-1:0] DATA_ZERO = {BITWIDTH{1'b0}};
  localparam logic [SHIFTW-1:0]   CNT_ZERO  = {SHIFTW{1'b0}};
  localparam logic [SHIFTW-1:0]   CNT_ONE   = {{(SHIFTW-1){1'b0}}, 1'b1};

  state_t              stateR, stateNextS;
  logic [BITWIDTH-1:0] accR, accNextS;
  logic [BITWIDTH-1:0] modR, modNextS;
  logic [SHIFTW-1:0]   cntR, cntNextS;
  logic                errR, errNextS;
  logic                validR, validNextS;
  logic                readyR, readyNextS;
  logic [BITWIDTH-1:0] dataR, dataNextS;
  logic [BITWIDTH-1:0] dblS;

  mod_doubler #(.BITWIDTH(BITWIDTH)) uDoubler (
    .a (accR),
    .m (modR),
    .r (dblS)
  );

  // Next-state and next-register values; everything holds unless iEn advances it.
  always_comb begin
    stateNextS = stateR;
    accNextS   = accR;
    modNextS   = modR;
    cntNextS   = cntR;
    errNextS   = errR;
    validNextS = validR;
    readyNextS = readyR;
    dataNextS  = dataR;
    case (stateR)
      S_IDLE: begin
        if (iValid && iEn) begin
          accNextS = iData;
          modNextS = iMod;
          cntNextS = iShift;
          if ((iMod == DATA_ZERO) || (iData >= iMod)) begin
            stateNextS = S_DONE;
            accNextS   = DATA_ZERO;
            errNextS   = ERR_OPERAND;
            dataNextS  = DATA_ZERO;
            validNextS = 1'b1;
            readyNextS = 1'b0;
          end else if (iShift == CNT_ZERO) begin
            stateNextS = S_DONE;
            errNextS   = ERR_NONE;
            dataNextS  = iData;
            validNextS = 1'b1;
            readyNextS = 1'b0;
          end else begin
            stateNextS = S_RUN;
            errNextS   = ERR_NONE;
            readyNextS = 1'b0;
          end
        end else begin
          stateNextS = S_IDLE;
        end
      end
      S_RUN: begin
        if (iEn) begin
          accNextS = dblS;
          cntNextS = cntR - CNT_ONE;
          if (cntR == CNT_ONE) begin
            stateNextS = S_DONE;
            dataNextS  = dblS;
            validNextS = 1'b1;
          end else begin
            stateNextS = S_RUN;
          end
        end else begin
          stateNextS = S_RUN;
        end
      end
      S_DONE: begin
        if (iReady && iEn) begin
          stateNextS = S_IDLE;
          validNextS = 1'b0;
          readyNextS = 1'b1;
        end else begin
          stateNextS = S_DONE;
        end
      end
      default: begin
        stateNextS = S_IDLE;
        errNextS   = ERR_NONE;
        validNextS = 1'b0;
        readyNextS = 1'b1;
      end
    endcase
  end

  // State and datapath registers; clear drops the op but keeps the last result on oData.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateR <= S_IDLE;
      accR   <= DATA_ZERO;
      modR   <= DATA_ZERO;
      cntR   <= CNT_ZERO;
      errR   <= ERR_NONE;
      validR <= 1'b0;
      readyR <= 1'b1;
      dataR  <= DATA_ZERO;
    end else if (iClr) begin
      stateR <= S_IDLE;
      accR   <= DATA_ZERO;
      modR   <= DATA_ZERO;
      cntR   <= CNT_ZERO;
      errR   <= ERR_NONE;
      validR <= 1'b0;
      readyR <= 1'b1;
    end else begin
      stateR <= stateNextS;
      accR   <= accNextS;
      modR   <= modNextS;
      cntR   <= cntNextS;
      errR   <= errNextS;
      validR <= validNextS;
      readyR <= readyNextS;
      dataR  <= dataNextS;
    end
  end

  assign oReady = readyR;
  assign oValid = validR;
  assign oData  = dataR;
  assign oErr   = errR;

endmodule

// File: tb/tb_mod_shift_mult.sv
// Directed self-checking bench for mod_shift_mult.
module tb_mod_shift_mult;

  localparam int BW = 32;
  localparam int SW = 5;

  logic          iClk = 1'b0;
  logic          iRst, iEn, iClr, iValid, iReady;
  logic [BW-1:0] iData, iMod;
  logic [SW-1:0] iShift;
  logic          oReady, oValid, oErr;
  logic [BW-1:0] oData;

  int testsRun    = 0;
  int testsFailed = 0;
  int lat;

  typedef struct {
    logic [31:0] m;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] expD;
    logic        expE;
    int          expLat;
  } vec_t;

  vec_t vecs[13];

  mod_shift_mult #(.BITWIDTH(BW), .SHIFTW(SW)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEn    (iEn),
    .iClr   (iClr),
    .iValid (iValid),
    .oReady (oReady),
    .iData  (iData),
    .iMod   (iMod),
    .iShift (iShift),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (oData),
    .oErr   (oErr)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for oReady, return #1 after the accept edge.
  task automatic startOp(input logic [31:0] d, input logic [31:0] m, input logic [4:0] s);
    int w = 0;
    @(negedge iClk);
    iData  = d;
    iMod   = m;
    iShift = s;
    iValid = 1'b1;
    while (!oReady && w < 50) begin
      @(negedge iClk);
      w++;
    end
    checkVal("accept_ready", {63'd0, oReady}, 64'd1);
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iData  = 32'hDEADBEEF;
    iMod   = 32'd0;
    iShift = 5'd7;
  endtask

  task automatic waitResult(input string tag, input logic [31:0] expD, input logic expE, input int expLat);
    lat = 0;
    while (!oValid && lat < 200) begin
      @(posedge iClk);
      #1;
      lat++;
    end
    checkVal({tag, "_valid"}, {63'd0, oValid}, 64'd1);
    checkVal({tag, "_data"}, {32'd0, oData}, {32'd0, expD});
    checkVal({tag, "_err"}, {63'd0, oErr}, {63'd0, expE});
    if (expLat >= 0) checkVal({tag, "_lat"}, 64'(lat), 64'(expLat));
  endtask

  task automatic drain(input string tag);
    @(negedge iClk);
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    checkVal({tag, "_rdy_after"}, {63'd0, oReady}, 64'd1);
    checkVal({tag, "_vld_after"}, {63'd0, oValid}, 64'd0);
  endtask

  initial begin
    logic        stable;
    logic [31:0] rm, rd;
    logic [4:0]  rs;
    longint unsigned golden;

    vecs[0]  = '{32'd23,         32'd5,          5'd2,  32'd20,         1'b0, 2};
    vecs[1]  = '{32'd23,         32'd22,         5'd2,  32'd19,         1'b0, 2};
    vecs[2]  = '{32'd23,         32'd7,          5'd0,  32'd7,          1'b0, -1};
    vecs[3]  = '{32'd23,         32'd1,          5'd31, 32'd6,          1'b0, 31};
    vecs[4]  = '{32'd0,          32'd5,          5'd3,  32'd0,          1'b1, -1};
    vecs[5]  = '{32'd23,         32'd23,         5'd4,  32'd0,          1'b1, -1};
    vecs[6]  = '{32'd1,          32'd0,          5'd5,  32'd0,          1'b0, 5};
    vecs[7]  = '{32'd97,         32'd50,         5'd3,  32'd12,         1'b0, 3};
    vecs[8]  = '{32'hFFFFFFFF,   32'd1,          5'd31, 32'h80000000,   1'b0, 31};
    vecs[9]  = '{32'hFFFFFFFF,   32'h80000000,   5'd1,  32'd1,          1'b0, 1};
    vecs[10] = '{32'hFFFFFFFF,   32'hFFFFFFFE,   5'd31, 32'h7FFFFFFF,   1'b0, 31};
    vecs[11] = '{32'd1000003,    32'd999999,     5'd4,  32'd999939,     1'b0, 4};
    vecs[12] = '{32'd7,          32'd6,          5'd3,  32'd6,          1'b0, 3};

    iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b0;
    iData = 32'd0; iMod = 32'd0; iShift = 5'd0;
    #3;
    checkVal("rst_ready", {63'd0, oReady}, 64'd1);
    checkVal("rst_valid", {63'd0, oValid}, 64'd0);
    checkVal("rst_data",  {32'd0, oData},  64'd0);
    checkVal("rst_err",   {63'd0, oErr},   64'd0);
    @(negedge iClk);
    iRst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      startOp(vecs[i].d, vecs[i].m, vecs[i].s);
      checkVal($sformatf("v%0d_busy", i), {63'd0, oReady}, 64'd0);
      waitResult($sformatf("v%0d", i), vecs[i].expD, vecs[i].expE, vecs[i].expLat);
      drain($sformatf("v%0d", i));
    end

    // Backpressure: result held for 10 cycles with iReady low
    startOp(32'd50, 32'd97, 5'd3);
    waitResult("bp", 32'd12, 1'b0, 3);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge iClk);
      #1;
      if (!(oValid === 1'b1 && oData === 32'd12 && oReady === 1'b0)) stable = 1'b0;
    end
    checkVal("bp_stable", {63'd0, stable}, 64'd1);
    drain("bp");

    // iEn low mid-RUN: 5 frozen edges stretch latency without changing the result
    startOp(32'd1, 32'd23, 5'd20);
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iEn = 1'b0;
    repeat (5) @(posedge iClk);
    #1;
    checkVal("freeze_valid", {63'd0, oValid}, 64'd0);
    @(negedge iClk);
    iEn = 1'b1;
    waitResult("freeze", 32'd6, 1'b0, 17);
    drain("freeze");

    // iClr mid-RUN: back to IDLE, op dropped, oData keeps the previous result
    startOp(32'd1, 32'd23, 5'd20);
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iClr = 1'b1;
    @(posedge iClk);
    #1;
    iClr = 1'b0;
    checkVal("clr_ready", {63'd0, oReady}, 64'd1);
    checkVal("clr_valid", {63'd0, oValid}, 64'd0);
    checkVal("clr_err",   {63'd0, oErr},   64'd0);
    checkVal("clr_data",  {32'd0, oData},  64'd6);
    repeat (25) @(posedge iClk);
    #1;
    checkVal("clr_dropped", {63'd0, oValid}, 64'd0);
    startOp(32'd5, 32'd23, 5'd2);
    waitResult("post_clr", 32'd20, 1'b0, 2);
    drain("post_clr");

    // iRst mid-RUN: immediate reset values
    startOp(32'd1, 32'd23, 5'd20);
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
    #1;
    checkVal("arst_ready", {63'd0, oReady}, 64'd1);
    checkVal("arst_valid", {63'd0, oValid}, 64'd0);
    checkVal("arst_data",  {32'd0, oData},  64'd0);
    checkVal("arst_err",   {63'd0, oErr},   64'd0);
    @(negedge iClk);
    iRst = 1'b0;
    startOp(32'd22, 32'd23, 5'd2);
    waitResult("post_rst", 32'd19, 1'b0, 2);
    drain("post_rst");

    // Golden-model ops: odd moduli, including the all-ones modulus
    for (int k = 0; k < 40; k++) begin
      rm = (k % 4 == 0) ? 32'hFFFFFFFF : ($urandom() | 32'd1);
      if (rm == 32'd1) rm = 32'd3;
      rd = $urandom() % rm;
      rs = 5'($urandom_range(0, 31));
      golden = ({32'd0, rd} << rs) % {32'd0, rm};
      startOp(rd, rm, rs);
      waitResult($sformatf("rnd%0d", k), golden[31:0], 1'b0, (rs == 5'd0) ? -1 : int'(rs));
      drain($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
